// File: rtl/aes_word_loader.sv
// aes_word_loader: word-serial front/back end for a pipelined aes_128 core.
// Upstream 32-bit writes build a 128-bit key and a 128-bit plaintext block.
// The loader issues the block into the free-running core and tags it through
// the core latency. It then buffers the ciphertext and streams it back out
// as 32-bit words. The number of blocks in flight plus buffered is
// credit-limited to the buffer depth, so a capture never finds the buffer full.
module aes_word_loader #(
  parameter int LATENCY    = 21,
  parameter int OBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         wr_sel,
  input  logic [31:0]  wr_data,
  output logic         key_valid,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [31:0]  rd_data,
  output logic         rd_last,
  output logic         busy
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(OBUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(OBUF_DEPTH - 1);

  logic [127:0]  key_sh;
  logic [127:0]  key_reg;
  logic [1:0]    key_cnt;
  logic [127:0]  st_sh;
  logic [1:0]    st_cnt;
  logic          st_full;
  logic          key_wr;
  logic          st_wr;
  logic          issue;
  logic          iss;
  logic [LATENCY:0] vld_sr;
  logic          cap;
  logic [CW-1:0] inflight;
  logic [CW-1:0] buf_count;
  logic [CW:0]   credit_used;
  logic [127:0]  obuf [OBUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    rd_idx;
  logic          rd_xfer;
  logic          pop;
  logic [127:0]  head;
  logic [31:0]   head_word;

  assign wr_ready    = ~(~wr_sel & st_full);
  assign key_wr      = wr_valid & wr_ready & wr_sel;
  assign st_wr       = wr_valid & wr_ready & ~wr_sel;
  assign credit_used = {1'b0, inflight} + {1'b0, buf_count};
  assign issue       = st_full & key_valid & (credit_used < DEPTH_LIM);
  // vld_sr[0] marks the edge the core samples its inputs; the top bit marks
  // the cycle in which the matching core_out is valid and must be captured.
  assign cap         = vld_sr[LATENCY];
  assign rd_valid    = (buf_count != '0);
  assign rd_xfer     = rd_valid & rd_ready;
  assign pop         = rd_xfer & (rd_idx == 2'd3);
  assign rd_last     = rd_valid & (rd_idx == 2'd3);
  assign busy        = (inflight != '0) | (buf_count != '0);

  // Key assembly: shift words in, publish the key on the fourth word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sh    <= '0;
      key_reg   <= '0;
      key_cnt   <= '0;
      key_valid <= 1'b0;
    end else if (key_wr) begin
      key_sh  <= {key_sh[95:0], wr_data};
      key_cnt <= key_cnt + 2'd1;
      if (key_cnt == 2'd0) begin
        key_valid <= 1'b0;
      end
      if (key_cnt == 2'd3) begin
        key_reg   <= {key_sh[95:0], wr_data};
        key_valid <= 1'b1;
      end
    end
  end

  // State assembly: shift words in and hold the block until it issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_sh   <= '0;
      st_cnt  <= '0;
      st_full <= 1'b0;
    end else begin
      if (st_wr) begin
        st_sh  <= {st_sh[95:0], wr_data};
        st_cnt <= st_cnt + 2'd1;
      end
      if (issue) begin
        st_full <= 1'b0;
      end else if (st_wr && st_cnt == 2'd3) begin
        st_full <= 1'b1;
      end
    end
  end

  // Issue register: drives the core and holds its inputs between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_state <= '0;
      core_key   <= '0;
      iss        <= 1'b0;
    end else begin
      iss <= issue;
      if (issue) begin
        core_state <= st_sh;
        core_key   <= key_reg;
      end
    end
  end

  // In-flight tracking: tag shift register and the in-flight block count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= {vld_sr[LATENCY-1:0], iss};
      if (issue && !cap) begin
        inflight <= inflight + CW'(1);
      end else if (!issue && cap) begin
        inflight <= inflight - CW'(1);
      end
    end
  end

  // Result storage: captured ciphertext blocks, no reset needed on data.
  always_ff @(posedge clk) begin
    if (cap) begin
      obuf[wr_ptr] <= core_out;
    end
  end

  // Result buffer bookkeeping: pointers, occupancy and word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      rd_idx    <= '0;
    end else begin
      if (cap) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      if (cap && !pop) begin
        buf_count <= buf_count + CW'(1);
      end else if (!cap && pop) begin
        buf_count <= buf_count - CW'(1);
      end
      if (rd_xfer) begin
        rd_idx <= rd_idx + 2'd1;
      end
    end
  end

  // Read serializer: select the current word of the head block.
  always_comb begin
    head      = obuf[rd_ptr];
    head_word = head[127:96];
    case (rd_idx)
      2'd0:    head_word = head[127:96];
      2'd1:    head_word = head[95:64];
      2'd2:    head_word = head[63:32];
      default: head_word = head[31:0];
    endcase
    rd_data = rd_valid ? head_word : 32'd0;
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: directed and randomized bench for aes_word_loader.
// A simple stand-in core produces FIPS-197 ciphertext for the reference
// vector and a keyed mixing function otherwise. A block-level model predicts
// the ciphertext word stream from the written keys and blocks.
module tb_aes_word_loader;

  localparam int LATENCY    = 21;
  localparam int OBUF_DEPTH = 4;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid;
  logic         wr_ready;
  logic         wr_sel;
  logic [31:0]  wr_data;
  logic         key_valid;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         rd_valid;
  logic         rd_ready;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         busy;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int issues = 0;
  int blocks_read = 0;
  int max_out = 0;
  int last_issue_cyc = 0;
  bit rdy_rand = 1'b0;
  logic [255:0] prev_core = '0;

  logic [127:0] m_key;
  bit           m_key_valid;
  logic [127:0] m_key_sh;
  int           m_key_n;
  logic [127:0] m_st_sh;
  int           m_st_n;
  logic [127:0] pend_q[$];
  logic [31:0]  exp_w[$];
  bit           exp_l[$];

  logic [127:0] pipe [0:LATENCY];

  aes_word_loader #(.LATENCY(LATENCY), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .key_valid(key_valid), .core_state(core_state), .core_key(core_key),
    .core_out(core_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] ref_cipher(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {s[63:0] ^ k[127:64], s[127:64] + k[63:0]} ^ {4{32'h9e3779b9}};
  endfunction

  // Stand-in core: samples its inputs every edge, result visible LATENCY edges later.
  always @(posedge clk) begin
    pipe[0] <= ref_cipher(core_state, core_key);
    for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LATENCY];

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void push_block(input logic [127:0] ct);
    for (int w = 0; w < 4; w++) begin
      exp_w.push_back(ct[127-32*w -: 32]);
      exp_l.push_back(w == 3);
    end
  endfunction

  // Scoreboard on transfers, plus issue and occupancy monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        if (exp_w.size() == 0) begin
          check_output("rd_unexpected", rd_valid, 0);
        end else begin
          check_output("rd_data", rd_data, exp_w[0]);
          check_output("rd_last", rd_last, exp_l[0]);
          if (exp_l[0]) blocks_read++;
          void'(exp_w.pop_front());
          void'(exp_l.pop_front());
        end
      end
      if ({core_state, core_key} != prev_core) begin
        issues++;
        last_issue_cyc = cyc;
      end
      if (issues - blocks_read > max_out) max_out = issues - blocks_read;
    end
    prev_core = {core_state, core_key};
  end

  // Random consumer back-pressure when enabled.
  always @(posedge clk) begin
    #2;
    if (rdy_rand) rd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_stimulus(input logic sel, input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check_output("wr_ready_wait", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    if (sel) begin
      if (m_key_n == 0) m_key_valid = 1'b0;
      m_key_sh = {m_key_sh[95:0], d};
      m_key_n++;
      if (m_key_n == 4) begin
        m_key_n = 0;
        m_key = m_key_sh;
        m_key_valid = 1'b1;
        while (pend_q.size() > 0) push_block(ref_cipher(pend_q.pop_front(), m_key));
      end
    end else begin
      m_st_sh = {m_st_sh[95:0], d};
      m_st_n++;
      if (m_st_n == 4) begin
        m_st_n = 0;
        if (m_key_valid) push_block(ref_cipher(m_st_sh, m_key));
        else pend_q.push_back(m_st_sh);
      end
    end
  endtask

  task automatic write_words(input logic sel, input logic [127:0] v, input int first, input int last);
    for (int i = first; i <= last; i++) apply_stimulus(sel, v[127-32*i -: 32]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_w.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_busy", busy, 0);
    check_output("drain_empty", exp_w.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_wr_ready"}, wr_ready, 1);
    check_output({tag, "_key_valid"}, key_valid, 0);
    check_output({tag, "_rd_valid"}, rd_valid, 0);
    check_output({tag, "_rd_last"}, rd_last, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_core_state"}, core_state, 0);
    check_output({tag, "_core_key"}, core_key, 0);
    check_output({tag, "_rd_data"}, rd_data, 0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int i0;
    int n;
    bit seen;
    logic [127:0] k1, k2, pt1, pt2;

    wr_valid = 1'b0;
    wr_sel   = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    m_key = '0; m_key_valid = 1'b0; m_key_sh = '0; m_key_n = 0;
    m_st_sh = '0; m_st_n = 0;

    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] FIPS-197 vector and issue latency");
    rd_ready = 1'b1;
    write_words(1'b1, FIPS_KEY, 0, 3);
    check_output("key_valid_set", key_valid, 1);
    write_words(1'b0, FIPS_PT, 0, 3);
    n = 0;
    while (!rd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("fips_latency", cyc - last_issue_cyc, LATENCY + 2);
    drain();

    $display("[TB] partial state writes");
    i0 = issues;
    pt1 = rand128();
    pt2 = rand128();
    write_words(1'b0, pt1, 0, 3);
    write_words(1'b0, pt2, 0, 1);
    wait_cycles(40);
    check_output("partial_no_issue", issues, i0 + 1);
    write_words(1'b0, pt2, 2, 3);
    wait_cycles(3);
    check_output("partial_issue", issues, i0 + 2);
    drain();

    $display("[TB] key change with a block in flight");
    k1 = rand128();
    k2 = rand128();
    write_words(1'b1, k1, 0, 3);
    i0 = issues;
    write_words(1'b0, rand128(), 0, 3);
    wait_cycles(3);
    write_words(1'b1, k2, 0, 1);
    check_output("key_valid_partial", key_valid, 0);
    write_words(1'b0, rand128(), 0, 3);
    wait_cycles(10);
    check_output("no_issue_key_invalid", issues, i0 + 1);
    write_words(1'b1, k2, 2, 3);
    wait_cycles(3);
    check_output("issue_after_key", issues, i0 + 2);
    drain();

    $display("[TB] back-to-back blocks under credit limit");
    rd_ready = 1'b0;
    write_words(1'b1, rand128(), 0, 3);
    i0 = issues;
    for (int b = 0; b < 5; b++) write_words(1'b0, rand128(), 0, 3);
    wait_cycles(40);
    check_output("credit_issue_count", issues, i0 + OBUF_DEPTH);
    wr_sel = 1'b0;
    #1;
    check_output("wr_ready_state_full", wr_ready, 0);
    wr_sel = 1'b1;
    #1;
    check_output("wr_ready_key", wr_ready, 1);
    check_output("stalled_rd_valid", rd_valid, 1);
    check_output("stalled_busy", busy, 1);
    check_output("stalled_rd_data", rd_data, exp_w[0]);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    write_words(1'b0, rand128(), 0, 3);
    drain();
    check_output("b2b_issue_count", issues, i0 + 6);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 3; r++) begin
      rdy_rand = 1'b1;
      write_words(1'b1, rand128(), 0, 3);
      for (int b = 0; b < 5; b++) write_words(1'b0, rand128(), 0, 3);
      drain();
    end
    rdy_rand = 1'b0;
    rd_ready = 1'b1;

    $display("[TB] reset while a block is in flight");
    write_words(1'b0, rand128(), 0, 3);
    wait_cycles(6);
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    exp_w.delete();
    exp_l.delete();
    pend_q.delete();
    m_key_valid = 1'b0; m_key_n = 0; m_st_n = 0;
    issues = 0;
    blocks_read = 0;
    wait_cycles(2);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    check_output("post_reset_rd_valid", seen, 0);
    check_output("post_reset_busy", busy, 0);

    check_output("credit_max", max_out <= OBUF_DEPTH, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
